// File: rtl/issue_ctrl.sv
// Dual-issue stage: picks 0/1/2 head entries from the instruction buffer, tracks
// pending long-latency destinations in a scoreboard and registers issued entries.
module issue_ctrl #(
  parameter int PAYLOAD_W = 160
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 ex_stall,
  input  logic                 backend_empty,
  input  logic                 i_a_valid,
  input  logic                 i_b_valid,
  input  logic [PAYLOAD_W-1:0] i_a_payload,
  input  logic [PAYLOAD_W-1:0] i_b_payload,
  input  logic [4:0]           i_a_dest,
  input  logic [4:0]           i_b_dest,
  input  logic [4:0]           i_a_r1,
  input  logic [4:0]           i_a_r2,
  input  logic [4:0]           i_b_r1,
  input  logic [4:0]           i_b_r2,
  input  logic                 i_a_src2_is_imm,
  input  logic                 i_b_src2_is_imm,
  input  logic                 i_a_is_branch,
  input  logic                 i_b_is_branch,
  input  logic                 i_a_is_mem,
  input  logic                 i_b_is_mem,
  input  logic                 i_a_is_muldiv,
  input  logic                 i_b_is_muldiv,
  input  logic                 i_a_long_lat,
  input  logic                 i_b_long_lat,
  input  logic                 i_a_solo,
  input  logic                 i_b_solo,
  input  logic [1:0]           i_wb_valid,
  input  logic [4:0]           i_wb_dest0,
  input  logic [4:0]           i_wb_dest1,
  output logic [1:0]           o_size,
  output logic                 o_a_valid,
  output logic                 o_b_valid,
  output logic [PAYLOAD_W-1:0] o_a_payload,
  output logic [PAYLOAD_W-1:0] o_b_payload,
  output logic [4:0]           o_a_dest,
  output logic [4:0]           o_b_dest,
  output logic [31:0]          o_dual_cnt
);

  logic [31:0]          sb_q, sb_d;
  logic                 a_valid_q, b_valid_q;
  logic [PAYLOAD_W-1:0] a_payload_q, b_payload_q;
  logic [4:0]           a_dest_q, b_dest_q;
  logic [31:0]          dual_cnt_q;
  logic                 a_issue, b_issue, b_pair_ok;

  function automatic logic busy(input logic [31:0] sb, input logic [4:0] r);
    return (r != 5'd0) && sb[r];
  endfunction

  // Issue decision for both lanes; b never issues without a.
  always_comb begin
    a_issue = 1'b0;
    b_issue = 1'b0;
    b_pair_ok = 1'b0;
    if (!reset) begin
      a_issue = i_a_valid && !flush && !ex_stall
                && !busy(sb_q, i_a_r1)
                && !(busy(sb_q, i_a_r2) && !i_a_src2_is_imm)
                && !(i_a_long_lat && busy(sb_q, i_a_dest))
                && (!i_a_solo || backend_empty);
      b_pair_ok = ((i_a_dest == 5'd0)
                   || ((i_a_dest != i_b_r1) && ((i_a_dest != i_b_r2) || i_b_src2_is_imm)))
                  && ((i_a_dest == 5'd0) || (i_a_dest != i_b_dest))
                  && !(i_a_is_mem && i_b_is_mem)
                  && !(i_a_is_muldiv && i_b_is_muldiv);
      b_issue = a_issue && i_b_valid && !i_a_solo && !i_b_solo && !i_a_is_branch
                && b_pair_ok
                && !busy(sb_q, i_b_r1)
                && !(busy(sb_q, i_b_r2) && !i_b_src2_is_imm)
                && !(i_b_long_lat && busy(sb_q, i_b_dest));
    end else begin
      a_issue = 1'b0;
    end
  end

  always_comb begin
    if (a_issue) begin
      o_size = b_issue ? 2'd2 : 2'd1;
    end else begin
      o_size = 2'd0;
    end
  end

  // Scoreboard next state: writeback clears first so a same-cycle set wins.
  always_comb begin
    sb_d = sb_q;
    if (i_wb_valid[0]) sb_d[i_wb_dest0] = 1'b0;
    else sb_d = sb_d;
    if (i_wb_valid[1]) sb_d[i_wb_dest1] = 1'b0;
    else sb_d = sb_d;
    if (a_issue && i_a_long_lat && (i_a_dest != 5'd0)) sb_d[i_a_dest] = 1'b1;
    else sb_d = sb_d;
    if (b_issue && i_b_long_lat && (i_b_dest != 5'd0)) sb_d[i_b_dest] = 1'b1;
    else sb_d = sb_d;
    sb_d[0] = 1'b0;
    if (flush) sb_d = 32'd0;
    else sb_d = sb_d;
  end

  // Pipeline register, scoreboard and dual-issue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      a_payload_q <= '0;
      b_payload_q <= '0;
      a_dest_q    <= 5'd0;
      b_dest_q    <= 5'd0;
      sb_q        <= 32'd0;
      dual_cnt_q  <= 32'd0;
    end else begin
      sb_q <= sb_d;
      if (o_size == 2'd2) dual_cnt_q <= dual_cnt_q + 32'd1;
      if (flush) begin
        a_valid_q <= 1'b0;
        b_valid_q <= 1'b0;
      end else if (!ex_stall) begin
        a_valid_q <= a_issue;
        b_valid_q <= b_issue;
        if (a_issue) begin
          a_payload_q <= i_a_payload;
          a_dest_q    <= i_a_dest;
        end
        if (b_issue) begin
          b_payload_q <= i_b_payload;
          b_dest_q    <= i_b_dest;
        end
      end
    end
  end

  assign o_a_valid   = a_valid_q;
  assign o_b_valid   = b_valid_q;
  assign o_a_payload = a_payload_q;
  assign o_b_payload = b_payload_q;
  assign o_a_dest    = a_dest_q;
  assign o_b_dest    = b_dest_q;
  assign o_dual_cnt  = dual_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: o_size checked combinationally each step,
// expected registered outputs queued at drive time and compared after the edge.
module tb_issue_ctrl;
  localparam int PW = 160;

  logic clk = 1'b0;
  logic reset, flush, ex_stall, backend_empty;
  logic a_valid, b_valid;
  logic [PW-1:0] a_payload, b_payload;
  logic [4:0] a_dest, b_dest, a_r1, a_r2, b_r1, b_r2;
  logic a_imm, b_imm, a_br, b_br, a_mem, b_mem, a_md, b_md, a_ll, b_ll, a_solo, b_solo;
  logic [1:0] wb_valid;
  logic [4:0] wb_dest0, wb_dest1;
  logic [1:0] o_size;
  logic o_a_valid, o_b_valid;
  logic [PW-1:0] o_a_payload, o_b_payload;
  logic [4:0] o_a_dest, o_b_dest;
  logic [31:0] o_dual_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    logic av, bv;
    logic [4:0] ad, bd;
    logic [PW-1:0] ap, bp;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  logic m_av = 1'b0, m_bv = 1'b0;
  logic [4:0] m_ad = 5'd0, m_bd = 5'd0;
  logic [PW-1:0] m_ap = '0, m_bp = '0;
  logic [31:0] m_cnt = 32'd0;

  always #5 clk = ~clk;

  issue_ctrl #(.PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_stall(ex_stall), .backend_empty(backend_empty),
    .i_a_valid(a_valid), .i_b_valid(b_valid),
    .i_a_payload(a_payload), .i_b_payload(b_payload),
    .i_a_dest(a_dest), .i_b_dest(b_dest),
    .i_a_r1(a_r1), .i_a_r2(a_r2), .i_b_r1(b_r1), .i_b_r2(b_r2),
    .i_a_src2_is_imm(a_imm), .i_b_src2_is_imm(b_imm),
    .i_a_is_branch(a_br), .i_b_is_branch(b_br),
    .i_a_is_mem(a_mem), .i_b_is_mem(b_mem),
    .i_a_is_muldiv(a_md), .i_b_is_muldiv(b_md),
    .i_a_long_lat(a_ll), .i_b_long_lat(b_ll),
    .i_a_solo(a_solo), .i_b_solo(b_solo),
    .i_wb_valid(wb_valid), .i_wb_dest0(wb_dest0), .i_wb_dest1(wb_dest1),
    .o_size(o_size), .o_a_valid(o_a_valid), .o_b_valid(o_b_valid),
    .o_a_payload(o_a_payload), .o_b_payload(o_b_payload),
    .o_a_dest(o_a_dest), .o_b_dest(o_b_dest), .o_dual_cnt(o_dual_cnt)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Default: nothing valid, no hazards, backend drained, fresh random payloads.
  task automatic clr();
    reset = 1'b0; flush = 1'b0; ex_stall = 1'b0; backend_empty = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
    b_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
    a_dest = 5'd0; b_dest = 5'd0; a_r1 = 5'd0; a_r2 = 5'd0; b_r1 = 5'd0; b_r2 = 5'd0;
    a_imm = 1'b0; b_imm = 1'b0; a_br = 1'b0; b_br = 1'b0; a_mem = 1'b0; b_mem = 1'b0;
    a_md = 1'b0; b_md = 1'b0; a_ll = 1'b0; b_ll = 1'b0; a_solo = 1'b0; b_solo = 1'b0;
    wb_valid = 2'b00; wb_dest0 = 5'd0; wb_dest1 = 5'd0;
  endtask

  task automatic set_a(input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2, input logic imm);
    a_valid = 1'b1; a_dest = d; a_r1 = r1; a_r2 = r2; a_imm = imm;
  endtask

  task automatic set_b(input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2, input logic imm);
    b_valid = 1'b1; b_dest = d; b_r1 = r1; b_r2 = r2; b_imm = imm;
  endtask

  // One cycle: check o_size, predict the register state, clock, compare.
  task automatic step(input string tag, input logic [1:0] es);
    exp_t e;
    #4;
    chk({tag, ".size"}, PW'(o_size), PW'(es));
    if (reset) begin
      m_av = 1'b0; m_bv = 1'b0; m_ad = 5'd0; m_bd = 5'd0; m_ap = '0; m_bp = '0; m_cnt = 32'd0;
    end else begin
      if (es == 2'd2) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m_av = 1'b0; m_bv = 1'b0;
      end else if (!ex_stall) begin
        m_av = (es != 2'd0);
        m_bv = (es == 2'd2);
        if (m_av) begin m_ad = a_dest; m_ap = a_payload; end
        if (m_bv) begin m_bd = b_dest; m_bp = b_payload; end
      end
    end
    exp_q.push_back('{tag, m_av, m_bv, m_ad, m_bd, m_ap, m_bp, m_cnt});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".a_valid"}, PW'(o_a_valid), PW'(e.av));
    chk({e.tag, ".b_valid"}, PW'(o_b_valid), PW'(e.bv));
    chk({e.tag, ".a_dest"}, PW'(o_a_dest), PW'(e.ad));
    chk({e.tag, ".b_dest"}, PW'(o_b_dest), PW'(e.bd));
    chk({e.tag, ".a_payload"}, o_a_payload, e.ap);
    chk({e.tag, ".b_payload"}, o_b_payload, e.bp);
    chk({e.tag, ".dual_cnt"}, PW'(o_dual_cnt), PW'(e.cnt));
    clr();
  endtask

  initial begin
    clr();
    reset = 1'b1; set_a(5'd4, 5'd1, 5'd2, 1'b0);
    step("reset0", 2'd0);
    reset = 1'b1;
    step("reset1", 2'd0);

    set_a(5'd4, 5'd1, 5'd2, 1'b0); set_b(5'd5, 5'd6, 5'd0, 1'b1);
    step("indep_pair", 2'd2);

    set_a(5'd7, 5'd1, 5'd2, 1'b0); set_b(5'd8, 5'd1, 5'd7, 1'b0);
    step("raw_r2", 2'd1);
    set_a(5'd7, 5'd1, 5'd2, 1'b0); set_b(5'd8, 5'd2, 5'd7, 1'b1);
    step("raw_imm_ok", 2'd2);
    set_a(5'd7, 5'd1, 5'd2, 1'b0); set_b(5'd8, 5'd7, 5'd2, 1'b1);
    step("raw_r1", 2'd1);
    b_valid = 1'b1; set_b(5'd8, 5'd1, 5'd2, 1'b0);
    step("no_a", 2'd0);

    // Load r3 and its consumer.
    set_a(5'd3, 5'd1, 5'd2, 1'b1); a_ll = 1'b1; a_mem = 1'b1;
    step("load_r3", 2'd1);
    set_a(5'd8, 5'd3, 5'd0, 1'b1);
    step("use_r3_wait0", 2'd0);
    set_a(5'd8, 5'd3, 5'd0, 1'b1);
    step("use_r3_wait1", 2'd0);
    set_a(5'd8, 5'd3, 5'd0, 1'b1); wb_valid = 2'b01; wb_dest0 = 5'd3;
    step("use_r3_wb", 2'd0);
    set_a(5'd8, 5'd3, 5'd0, 1'b1);
    step("use_r3_go", 2'd1);

    // Stray writeback of r3 with a new load to r3 in the same cycle.
    set_a(5'd3, 5'd1, 5'd2, 1'b0); a_ll = 1'b1; wb_valid = 2'b10; wb_dest1 = 5'd3;
    step("wb_set_same", 2'd1);
    set_a(5'd8, 5'd1, 5'd3, 1'b0);
    step("r3_still_busy", 2'd0);
    set_a(5'd9, 5'd1, 5'd2, 1'b0); a_ll = 1'b1; a_md = 1'b1;
    set_b(5'd10, 5'd1, 5'd9, 1'b0);
    step("mul_r9_b_raw", 2'd1);
    set_a(5'd11, 5'd1, 5'd2, 1'b0); set_b(5'd12, 5'd9, 5'd0, 1'b1);
    step("b_src_busy", 2'd1);
    set_a(5'd11, 5'd1, 5'd2, 1'b0); set_b(5'd9, 5'd1, 5'd0, 1'b1); b_ll = 1'b1;
    step("b_waw_busy", 2'd1);

    // Solo entry waits for the backend and never pairs.
    for (int i = 0; i < 3; i++) begin
      set_a(5'd13, 5'd1, 5'd0, 1'b1); a_solo = 1'b1; backend_empty = 1'b0;
      set_b(5'd14, 5'd2, 5'd0, 1'b1);
      step($sformatf("solo_wait%0d", i), 2'd0);
    end
    set_a(5'd13, 5'd1, 5'd0, 1'b1); a_solo = 1'b1; set_b(5'd14, 5'd2, 5'd0, 1'b1);
    step("solo_go", 2'd1);
    set_a(5'd15, 5'd1, 5'd0, 1'b1); set_b(5'd14, 5'd2, 5'd0, 1'b1); b_solo = 1'b1;
    step("b_solo", 2'd1);

    // Stall holds outputs; flush under stall clears valids and the scoreboard.
    set_a(5'd16, 5'd1, 5'd2, 1'b0); set_b(5'd17, 5'd6, 5'd0, 1'b1); ex_stall = 1'b1;
    step("stall", 2'd0);
    set_a(5'd16, 5'd1, 5'd2, 1'b0); set_b(5'd17, 5'd6, 5'd0, 1'b1); ex_stall = 1'b1; flush = 1'b1;
    step("flush_stall", 2'd0);
    set_a(5'd18, 5'd3, 5'd9, 1'b0); set_b(5'd19, 5'd3, 5'd9, 1'b0);
    step("after_flush", 2'd2);

    // Structural conflicts.
    set_a(5'd20, 5'd1, 5'd0, 1'b1); a_mem = 1'b1; set_b(5'd21, 5'd2, 5'd0, 1'b1); b_mem = 1'b1;
    step("two_mem", 2'd1);
    set_a(5'd20, 5'd1, 5'd0, 1'b1); a_md = 1'b1; set_b(5'd21, 5'd2, 5'd0, 1'b1); b_md = 1'b1;
    step("two_muldiv", 2'd1);
    set_a(5'd0, 5'd1, 5'd0, 1'b1); a_br = 1'b1; set_b(5'd21, 5'd2, 5'd0, 1'b1);
    step("branch_a", 2'd1);
    set_a(5'd22, 5'd1, 5'd0, 1'b1); set_b(5'd22, 5'd2, 5'd0, 1'b1);
    step("waw_pair", 2'd1);
    set_a(5'd0, 5'd1, 5'd0, 1'b1); set_b(5'd23, 5'd0, 5'd0, 1'b0);
    step("a_no_dest", 2'd2);

    // Reset in the middle of traffic.
    set_a(5'd24, 5'd1, 5'd0, 1'b1); set_b(5'd25, 5'd2, 5'd0, 1'b1); reset = 1'b1;
    step("mid_reset", 2'd0);
    set_a(5'd24, 5'd1, 5'd0, 1'b1); set_b(5'd25, 5'd2, 5'd0, 1'b1);
    step("post_reset", 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Dual-issue issue stage directly downstream of the instruction buffer.
- Each cycle it inspects the buffer's two head entries (a = older, b = younger) and decides how many to issue: 0, 1 or 2.
- It returns that count to the buffer as its dequeue size and registers the issued entries into the ID/EX pipeline register.
- It owns a 32-entry scoreboard of pending long-latency writes (load, mul, div) and stalls RAW/WAW hazards on those registers.

Parameters:
- PAYLOAD_W, 160, width of the opaque per-instruction payload (pc, opcode, imm, branch, csr fields); carried through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  backend redirect; kills everything in this stage
- ex_stall  in  1  EX cannot accept a new pair this cycle
- backend_empty  in  1  no instruction in flight in EX/MEM/WB
- i_a_valid, i_b_valid  in  1 each  buffer head entries valid
- i_a_payload, i_b_payload  in  PAYLOAD_W each  opaque entry payload
- i_a_dest, i_b_dest  in  5 each  destination register (0 = none)
- i_a_r1, i_a_r2, i_b_r1, i_b_r2  in  5 each  source registers
- i_a_src2_is_imm, i_b_src2_is_imm  in  1 each  r2 not read
- i_a_is_branch, i_b_is_branch  in  1 each  entry is a branch/jump
- i_a_is_mem, i_b_is_mem  in  1 each  entry uses the single memory port
- i_a_is_muldiv, i_b_is_muldiv  in  1 each  entry uses the single mul/div unit
- i_a_long_lat, i_b_long_lat  in  1 each  result arrives via the wb port (load/mul/div)
- i_a_solo, i_b_solo  in  1 each  spec op, idle or have_excp; must issue alone after backend drains
- i_wb_valid  in  2  long-latency writeback valid, two lanes
- i_wb_dest0, i_wb_dest1  in  5 each  writeback destination per lane
- o_size  out  2  dequeue count to the buffer (combinational)
- o_a_valid, o_b_valid  out  1 each  registered issue valids
- o_a_payload, o_b_payload  out  PAYLOAD_W each  registered payloads
- o_a_dest, o_b_dest  out  5 each  registered destinations
- o_dual_cnt  out  32  count of dual-issue cycles (perf)

Behaviour:
- Reset (sync): o_a_valid/o_b_valid=0, all output payload/dest regs=0, scoreboard=0, o_dual_cnt=0. o_size=0 while reset is high.
- busy(r): scoreboard bit r; bit 0 is hardwired 0.
- A issuable: i_a_valid & !flush & !ex_stall & !busy(a.r1) & !(busy(a.r2) & !a.src2_is_imm) & !(a.long_lat & busy(a.dest)) & (!a.solo | backend_empty).
- B issuable: A issuable & i_b_valid & !a.solo & !b.solo & !a.is_branch, with all of:
  - no RAW on a: a.dest==0 | (a.dest!=b.r1 & (a.dest!=b.r2 | b.src2_is_imm));
  - no WAW: a.dest==0 | a.dest!=b.dest;
  - no shared unit: !(a.is_mem & b.is_mem) & !(a.is_muldiv & b.is_muldiv);
  - b's sources not busy, and !(b.long_lat & busy(b.dest)), using the same rules as a.
- o_size = A ? (B ? 2 : 1) : 0. o_size is never 2 unless o_size would be 1 for the same a. o_size=0 when i_a_valid=0.
- Output register:
  - flush: both valids <= 0.
  - else ex_stall: hold all outputs.
  - else: o_a_valid<=A, o_b_valid<=B; payload/dest captured for issued lanes; non-issued lanes keep old payload with valid 0.
- Scoreboard update each cycle, in this order:
  - clear bit i_wb_destN for each asserted i_wb_valid[N];
  - then set bit dest for each issued entry with long_lat & dest!=0.
  - Same-cycle clear and set of one register: set wins.
- flush: scoreboard cleared entirely; in-flight long ops are killed by the backend, and any stray wb after a flush is harmless (clear of a 0 bit). Flush has priority over every set.
- Solo entry: issues only when backend_empty=1 and never pairs. Entry b behind a solo a waits a cycle.
- o_dual_cnt increments by 1 in each cycle with o_size==2; wraps at 2^32.
- Latency: entry visible at the inputs with no hazard -> o_x_valid high next cycle.

Test Plan:
- Independent pair (a: add r4<-r1,r2; b: sub r5<-r6,imm), no stall -> o_size=2; next cycle o_a_valid=o_b_valid=1, o_a_dest=4, o_b_dest=5; o_dual_cnt=1.
- RAW in pair (a.dest=7, b.r2=7, b.src2_is_imm=0) -> o_size=1. With b.src2_is_imm=1 and b.r1!=7 -> o_size=2.
- Load r3 issued, then a reads r3 -> o_size=0 until i_wb_valid=2'b01, i_wb_dest0=3. Next cycle o_size>=1. Same-cycle wb r3 and new load to r3: bit 3 stays set.
- Solo a (csr op), backend_empty=0 for 3 cycles -> o_size=0 for 3 cycles. At backend_empty=1: o_size=1, b not issued even if independent.
- ex_stall=1 with valid pair -> o_size=0, outputs held. flush during stall with scoreboard bits 3,9 set -> next cycle valids=0, scoreboard=0, and an instruction reading r3 issues immediately.
- Two mem ops (a.is_mem=b.is_mem=1), or a.is_branch=1 -> o_size=1. Reset asserted mid-operation -> next cycle all valids=0, o_dual_cnt=0.
